// File: rtl/rom_window_fetch_pkg.sv
// Shared types and defaults for the sequential ROM window fetcher.
package rom_win_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, VALID} state_e;

  localparam int ADDR_W_DFLT  = 19;
  localparam int DATA_W_DFLT  = 16;
  localparam int WIN_W_DFLT   = 3;
  localparam int WIN_H_DFLT   = 3;
  localparam int STRIDE_DFLT  = 640;
  localparam int DEPTH_DFLT   = 307200;
  localparam int ROM_LAT_DFLT = 1;
  localparam int N_TAPS       = WIN_W_DFLT * WIN_H_DFLT;

  // Width of a counter/index covering 0..n-1, never below one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rom_window_fetch_if.sv
// Request, ROM and window-output signals of the window fetcher.
interface rom_window_fetch_if import rom_win_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int TAPS   = N_TAPS
);
  logic                   req_valid;
  logic                   req_ready;
  logic [ADDR_W-1:0]      req_addr;
  logic                   rom_en;
  logic [ADDR_W-1:0]      rom_addr;
  logic [DATA_W-1:0]      rom_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAPS*DATA_W-1:0] out_data;

  // slave: the fetcher itself; master: requester, ROM and consumer side.
  modport slave (
    input  req_valid, req_addr, rom_rdata, out_ready,
    output req_ready, rom_en, rom_addr, out_valid, out_data
  );
  modport master (
    output req_valid, req_addr, rom_rdata, out_ready,
    input  req_ready, rom_en, rom_addr, out_valid, out_data
  );
endinterface

// File: rtl/rom_window_fetch_addr_gen.sv
// Walks the window taps row-major: base + r*STRIDE + c, with in-range and last-tap flags.
module rom_win_addr_gen import rom_win_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int WIN_W  = WIN_W_DFLT,
  parameter int WIN_H  = WIN_H_DFLT,
  parameter int STRIDE = STRIDE_DFLT,
  parameter int DEPTH  = DEPTH_DFLT
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            step,
  input  logic [ADDR_W-1:0]               base,
  output logic [ADDR_W-1:0]               addr,
  output logic                            in_range,
  output logic [idx_w(WIN_W*WIN_H)-1:0]   tap,
  output logic                            last
);
  localparam int NT = WIN_W * WIN_H;
  localparam int TW = idx_w(NT);
  localparam int CW = idx_w(WIN_W);
  localparam bit FULL_MAP = (longint'(DEPTH) >= (longint'(1) << ADDR_W));
  localparam logic [ADDR_W:0] DEPTH_V  = FULL_MAP ? '0 : (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] STRIDE_V = (ADDR_W+1)'(STRIDE);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W:0]   roff_q, roff_d;
  logic [TW-1:0]     tap_q, tap_d;
  logic [ADDR_W:0]   full;

  always_comb begin
    base_d = base_q;
    col_d  = col_q;
    roff_d = roff_q;
    tap_d  = tap_q;
    if (start) begin
      base_d = base;
      col_d  = '0;
      roff_d = '0;
      tap_d  = '0;
    end else if (step) begin
      tap_d = tap_q + TW'(1);
      // Row offset is accumulated rather than multiplied.
      if (col_q == CW'(WIN_W - 1)) begin
        col_d  = '0;
        roff_d = roff_q + STRIDE_V;
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q <= '0;
      col_q  <= '0;
      roff_q <= '0;
      tap_q  <= '0;
    end else begin
      base_q <= base_d;
      col_q  <= col_d;
      roff_q <= roff_d;
      tap_q  <= tap_d;
    end
  end

  // One extra bit so a sum past 2^ADDR_W reads as out of image.
  assign full     = {1'b0, base_q} + roff_q + (ADDR_W+1)'(col_q);
  assign addr     = full[ADDR_W-1:0];
  assign in_range = FULL_MAP ? 1'b1 : (full < DEPTH_V);
  assign tap      = tap_q;
  assign last     = (tap_q == TW'(NT - 1));

endmodule

// File: rtl/rom_window_fetch.sv
// Sequential window reader: one ROM tap per cycle, zero-padded outside the image, valid/ready output.
module rom_window_fetch import rom_win_pkg::*; #(
  parameter int ADDR_W  = ADDR_W_DFLT,
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int WIN_W   = WIN_W_DFLT,
  parameter int WIN_H   = WIN_H_DFLT,
  parameter int STRIDE  = STRIDE_DFLT,
  parameter int DEPTH   = DEPTH_DFLT,
  parameter int ROM_LAT = ROM_LAT_DFLT
) (
  input logic               clk,
  input logic               rst,
  rom_window_fetch_if.slave bus
);
  localparam int NT = WIN_W * WIN_H;
  localparam int TW = idx_w(NT);
  localparam int LW = idx_w(ROM_LAT);

  typedef struct packed {
    logic          vld;
    logic          inr;
    logic [TW-1:0] idx;
  } tag_t;

  state_e                     state_q, state_d;
  logic [LW-1:0]              drain_q, drain_d;
  tag_t                       tag_in;
  tag_t [ROM_LAT:1]           tag_q, tag_d;
  logic [NT-1:0][DATA_W-1:0]  win_q, win_d;
  logic [ADDR_W-1:0]          rom_addr_q, rom_addr_d;

  logic              start, step, rom_en;
  logic              gen_inr, gen_last;
  logic [ADDR_W-1:0] gen_addr;
  logic [TW-1:0]     gen_tap;

  rom_win_addr_gen #(
    .ADDR_W (ADDR_W),
    .WIN_W  (WIN_W),
    .WIN_H  (WIN_H),
    .STRIDE (STRIDE),
    .DEPTH  (DEPTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .step     (step),
    .base     (bus.req_addr),
    .addr     (gen_addr),
    .in_range (gen_inr),
    .tap      (gen_tap),
    .last     (gen_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      IDLE:  if (bus.req_valid) state_d = ISSUE;
      ISSUE: if (gen_last) begin
               state_d = DRAIN;
               drain_d = '0;
             end
      DRAIN: begin
               drain_d = drain_q + LW'(1);
               if (drain_q == LW'(ROM_LAT - 1)) state_d = VALID;
             end
      VALID: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start  = (state_q == IDLE) && bus.req_valid;
    step   = (state_q == ISSUE);
    rom_en = step && gen_inr;
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = rom_en ? gen_addr : rom_addr_q;
  assign bus.out_valid = (state_q == VALID);
  assign bus.out_data  = win_q;

  // Tag rides alongside the ROM read so each return knows its slot and whether to pad.
  always_comb begin
    tag_in     = '{vld: step, inr: gen_inr, idx: gen_tap};
    tag_d[1]   = tag_in;
    for (int i = 2; i <= ROM_LAT; i++) tag_d[i] = tag_q[i-1];
    rom_addr_d = bus.rom_addr;
    win_d      = win_q;
    if (tag_q[ROM_LAT].vld)
      win_d[tag_q[ROM_LAT].idx] = tag_q[ROM_LAT].inr ? bus.rom_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_q    <= '0;
      tag_q      <= '0;
      win_q      <= '0;
      rom_addr_q <= '0;
    end else begin
      drain_q    <= drain_d;
      tag_q      <= tag_d;
      win_q      <= win_d;
      rom_addr_q <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_rom_window_fetch.sv
// Randomized bench: two fetchers (clipped image and full-map wrap) in lockstep against a window model.
module tb_rom_window_fetch;
  localparam int AW   = 19;
  localparam int DW   = 16;
  localparam int NT   = 9;
  localparam int STR  = 640;
  localparam int DEP  = 307200;
  localparam int FULL = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  rom_window_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .TAPS(NT)) bus ();
  rom_window_fetch_if #(.ADDR_W(AW), .DATA_W(DW), .TAPS(NT)) bus_w ();

  rom_window_fetch #(.ADDR_W(AW), .DATA_W(DW), .WIN_W(3), .WIN_H(3), .STRIDE(STR),
                     .DEPTH(DEP), .ROM_LAT(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  rom_window_fetch #(.ADDR_W(AW), .DATA_W(DW), .WIN_W(3), .WIN_H(3), .STRIDE(STR),
                     .DEPTH(FULL), .ROM_LAT(1)) dut_w (.clk(clk), .rst(rst), .bus(bus_w));

  always #5 clk = ~clk;

  // ROM contents: mem[a] = a[15:0], one-cycle read latency.
  logic [DW-1:0] rom_q, rom_w_q;
  always @(posedge clk) begin
    if (bus.rom_en)   rom_q   <= bus.rom_addr[DW-1:0];
    if (bus_w.rom_en) rom_w_q <= bus_w.rom_addr[DW-1:0];
  end
  assign bus.rom_rdata     = rom_q;
  assign bus_w.rom_rdata   = rom_w_q;
  assign bus_w.req_valid   = bus.req_valid;
  assign bus_w.req_addr    = bus.req_addr;
  assign bus_w.out_ready   = bus.out_ready;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NT*DW-1:0] model(input int base, input int depth);
    logic [NT*DW-1:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        int full;
        full = base + r*STR + c;
        if (depth >= FULL || full < depth) w[(r*3+c)*DW +: DW] = DW'(full % FULL);
      end
    return w;
  endfunction

  task automatic chk_reset();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rom_en",    bus.rom_en, 0);
    chk("rst_rom_addr",  bus.rom_addr, 0);
    chk("rst_out_data",  bus.out_data, 0);
    chk("rst_w_data",    bus_w.out_data, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // abort_k < NT: reset while tap abort_k is issued; abort_k == NT: reset while window is valid.
  task automatic run_window(input int base, input int hold, input int abort_k);
    logic [NT*DW-1:0] em, ew;
    int n;
    em = model(base, DEP);
    ew = model(base, FULL);
    @(negedge clk);
    chk("req_ready", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = AW'(base);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_addr  = AW'($urandom);
    for (int k = 0; k < NT; k++) begin
      int full;
      full = base + (k/3)*STR + k%3;
      if (k == abort_k) begin
        do_reset();
        return;
      end
      chk("rom_en", bus.rom_en, full < DEP);
      if (full < DEP) chk("rom_addr", bus.rom_addr, full % FULL);
      chk("rom_en_w", bus_w.rom_en, 1);
      chk("rom_addr_w", bus_w.rom_addr, full % FULL);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
    end
    chk("drain_valid", bus.out_valid, 0);
    bus.out_ready = (hold == 0);
    @(negedge clk);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 0);
    chk("win", bus.out_data, em);
    chk("win_w", bus_w.out_data, ew);
    if (abort_k == NT) begin
      do_reset();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'($urandom);
      bus.req_addr  = AW'($urandom);
      @(negedge clk);
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_data", bus.out_data, em);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("gap_req_ready", bus.req_ready, 1);
    chk("post_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    int base, sel;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset();
    rst = 1'b0;

    run_window(32'h00200, 0, -1);
    run_window(32'h4AFEC, 5, -1);
    run_window(32'h7FFFF, 1, -1);
    run_window(32'h4AFEC, 0, 4);
    run_window(32'h4AFEC, 0, -1);
    run_window(32'h01234, 2, NT);
    run_window(32'h00200, 1, -1);

    for (int i = 0; i < 14; i++) begin
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      base = int'($urandom_range(0, FULL - 1));
      else if (sel == 1) base = DEP - 1 - int'($urandom_range(0, 1400));
      else               base = FULL - 1 - int'($urandom_range(0, 1400));
      run_window(base, int'($urandom_range(0, 3)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
